// File: rtl/tdpsram_req_ctrl_if.sv
// Request/response stream bundle between two clients (A, B) and the dual-port SRAM controller.
interface tdpsram_req_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DATA_DEPTH = 1024,
   parameter int unsigned BYTE_SIZE  = 8
);
   localparam int unsigned AW = $clog2(DATA_DEPTH);
   localparam int unsigned NB = DATA_WIDTH / BYTE_SIZE;

   logic                  a_req_valid_i;
   logic                  a_req_ready_o;
   logic [AW-1:0]         a_req_addr_i;
   logic [NB-1:0]         a_req_we_i;
   logic [DATA_WIDTH-1:0] a_req_wdata_i;
   logic                  a_resp_valid_o;
   logic                  a_resp_ready_i;
   logic [DATA_WIDTH-1:0] a_resp_rdata_o;

   logic                  b_req_valid_i;
   logic                  b_req_ready_o;
   logic [AW-1:0]         b_req_addr_i;
   logic [NB-1:0]         b_req_we_i;
   logic [DATA_WIDTH-1:0] b_req_wdata_i;
   logic                  b_resp_valid_o;
   logic                  b_resp_ready_i;
   logic [DATA_WIDTH-1:0] b_resp_rdata_o;

   modport master (
      output a_req_valid_i, a_req_addr_i, a_req_we_i, a_req_wdata_i, a_resp_ready_i,
      input  a_req_ready_o, a_resp_valid_o, a_resp_rdata_o,
      output b_req_valid_i, b_req_addr_i, b_req_we_i, b_req_wdata_i, b_resp_ready_i,
      input  b_req_ready_o, b_resp_valid_o, b_resp_rdata_o
   );

   modport slave (
      input  a_req_valid_i, a_req_addr_i, a_req_we_i, a_req_wdata_i, a_resp_ready_i,
      output a_req_ready_o, a_resp_valid_o, a_resp_rdata_o,
      input  b_req_valid_i, b_req_addr_i, b_req_we_i, b_req_wdata_i, b_resp_ready_i,
      output b_req_ready_o, b_resp_valid_o, b_resp_rdata_o
   );
endinterface

// File: rtl/tdpsram_req_ctrl.sv
// Drives both ports of a true-dual-port SRAM from two valid/ready streams, buffering
// responses in 2-entry FIFOs and round-robin resolving same-address collisions.
module tdpsram_req_ctrl #(
   parameter  int unsigned DATA_WIDTH = 32,
   parameter  int unsigned DATA_DEPTH = 1024,
   parameter  int unsigned BYTE_SIZE  = 8,
   localparam int unsigned AW         = $clog2(DATA_DEPTH),
   localparam int unsigned NB         = DATA_WIDTH / BYTE_SIZE
) (
   input  logic                  clk,
   input  logic                  rst,
   tdpsram_req_ctrl_if.slave     s,
   output logic [AW-1:0]         addr0_o,
   output logic                  en0_o,
   output logic [NB-1:0]         we0_o,
   output logic [DATA_WIDTH-1:0] wdata0_o,
   input  logic [DATA_WIDTH-1:0] rdata0_i,
   output logic [AW-1:0]         addr1_o,
   output logic                  en1_o,
   output logic [NB-1:0]         we1_o,
   output logic [DATA_WIDTH-1:0] wdata1_o,
   input  logic [DATA_WIDTH-1:0] rdata1_i
);

   // Index 0 is stream A / SRAM port 0, index 1 is stream B / SRAM port 1.
   logic [1:0]            req_valid, req_ready, accept, space;
   logic [1:0]            resp_valid, resp_ready, pop;
   logic [AW-1:0]         req_addr   [2];
   logic [NB-1:0]         req_we     [2];
   logic [DATA_WIDTH-1:0] req_wdata  [2];
   logic [DATA_WIDTH-1:0] rdata      [2];
   logic [DATA_WIDTH-1:0] resp_rdata [2];

   logic [1:0]            count [2];
   logic [1:0]            inflight, wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] fifo [2][2];
   logic                  prio_b, conflict;

   assign req_valid    = {s.b_req_valid_i, s.a_req_valid_i};
   assign resp_ready   = {s.b_resp_ready_i, s.a_resp_ready_i};
   assign req_addr[0]  = s.a_req_addr_i;
   assign req_addr[1]  = s.b_req_addr_i;
   assign req_we[0]    = s.a_req_we_i;
   assign req_we[1]    = s.b_req_we_i;
   assign req_wdata[0] = s.a_req_wdata_i;
   assign req_wdata[1] = s.b_req_wdata_i;
   assign rdata[0]     = rdata0_i;
   assign rdata[1]     = rdata1_i;

   // Ready looks only at registered occupancy so a same-cycle pop never feeds back.
   always_comb begin
      space[0] = !rst && ((3'(count[0]) + 3'(inflight[0])) < 3'd2);
      space[1] = !rst && ((3'(count[1]) + 3'(inflight[1])) < 3'd2);
      conflict = (&req_valid) && (req_addr[0] == req_addr[1]) && (&space);
      req_ready[0] = space[0] && !(conflict && prio_b);
      req_ready[1] = space[1] && !(conflict && !prio_b);
      accept = req_valid & req_ready;
      resp_valid[0] = !rst && (count[0] != 2'd0);
      resp_valid[1] = !rst && (count[1] != 2'd0);
      pop = resp_valid & resp_ready;
      resp_rdata[0] = fifo[0][rd_ptr[0]];
      resp_rdata[1] = fifo[1][rd_ptr[1]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count[0] <= 2'd0;
         count[1] <= 2'd0;
         inflight <= 2'b00;
         wr_ptr   <= 2'b00;
         rd_ptr   <= 2'b00;
         prio_b   <= 1'b0;
      end else begin
         inflight <= accept;
         if (conflict) prio_b <= !prio_b;
         for (int i = 0; i < 2; i++) begin
            if (inflight[i]) wr_ptr[i] <= !wr_ptr[i];
            if (pop[i])      rd_ptr[i] <= !rd_ptr[i];
            count[i] <= count[i] + 2'(inflight[i]) - 2'(pop[i]);
         end
      end
   end

   // Response storage; occupancy above decides which entries are live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (inflight[i]) fifo[i][wr_ptr[i]] <= rdata[i];
      end
   end

   assign s.a_req_ready_o  = req_ready[0];
   assign s.b_req_ready_o  = req_ready[1];
   assign s.a_resp_valid_o = resp_valid[0];
   assign s.b_resp_valid_o = resp_valid[1];
   assign s.a_resp_rdata_o = resp_rdata[0];
   assign s.b_resp_rdata_o = resp_rdata[1];

   assign addr0_o  = req_addr[0];
   assign en0_o    = accept[0];
   assign we0_o    = accept[0] ? req_we[0] : NB'(0);
   assign wdata0_o = req_wdata[0];
   assign addr1_o  = req_addr[1];
   assign en1_o    = accept[1];
   assign we1_o    = accept[1] ? req_we[1] : NB'(0);
   assign wdata1_o = req_wdata[1];

endmodule

// File: tb/tb_tdpsram_req_ctrl.sv
// Directed bench for tdpsram_req_ctrl with a write-first, 1-cycle-latency TDP SRAM model.
module tb_tdpsram_req_ctrl;
   localparam int unsigned DW = 32;
   localparam int unsigned DD = 1024;
   localparam int unsigned BS = 8;
   localparam int unsigned AW = 10;
   localparam int unsigned NB = 4;

   logic clk = 1'b0;
   logic rst;
   logic [AW-1:0] addr0, addr1;
   logic          en0, en1;
   logic [NB-1:0] we0, we1;
   logic [DW-1:0] wdata0, wdata1, rdata0, rdata1;

   int total = 0;
   int bad   = 0;

   tdpsram_req_ctrl_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .BYTE_SIZE(BS)) bus ();

   tdpsram_req_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .BYTE_SIZE(BS)) dut (
      .clk(clk), .rst(rst), .s(bus),
      .addr0_o(addr0), .en0_o(en0), .we0_o(we0), .wdata0_o(wdata0), .rdata0_i(rdata0),
      .addr1_o(addr1), .en1_o(en1), .we1_o(we1), .wdata1_o(wdata1), .rdata1_i(rdata1)
   );

   always #5 clk = ~clk;

   // SRAM model: word i preloads to 0xA0000000|i, except 0x020 = 0x11223344.
   logic [DW-1:0] mem [DD];
   logic          init_done = 1'b0;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [NB-1:0] we,
                                           input logic [DW-1:0] wd);
      logic [DW-1:0] r;
      r = old;
      for (int i = 0; i < int'(NB); i++) if (we[i]) r[i*8 +: 8] = wd[i*8 +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < int'(DD); i++) mem[i] <= 32'hA000_0000 | 32'(i);
         mem[32'h20] <= 32'h1122_3344;
         init_done <= 1'b1;
      end else begin
         if (en0) begin
            mem[addr0] <= merge(mem[addr0], we0, wdata0);
            rdata0     <= merge(mem[addr0], we0, wdata0);
         end
         if (en1) begin
            mem[addr1] <= merge(mem[addr1], we1, wdata1);
            rdata1     <= merge(mem[addr1], we1, wdata1);
         end
      end
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // The SRAM must never see both ports enabled on one address.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         total++;
         assert (!(en0 && en1 && addr0 == addr1)) else begin
            bad++;
            $error("FAIL same_addr observed=%h expected=0", {en0, en1});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   int na, nb;

   initial begin
      rst = 1'b1;
      bus.a_req_valid_i = 1'b0; bus.a_req_addr_i = '0; bus.a_req_we_i = '0; bus.a_req_wdata_i = '0;
      bus.b_req_valid_i = 1'b0; bus.b_req_addr_i = '0; bus.b_req_we_i = '0; bus.b_req_wdata_i = '0;
      bus.a_resp_ready_i = 1'b0; bus.b_resp_ready_i = 1'b0;
      cyc(); cyc();

      // Reset: nothing accepted or presented even with a request pending
      bus.a_req_valid_i = 1'b1; bus.a_req_addr_i = 10'h010;
      bus.b_req_valid_i = 1'b1; bus.b_req_addr_i = 10'h011;
      @(negedge clk);
      chk("rst_a_ready", 32'(bus.a_req_ready_o), 32'd0);
      chk("rst_b_ready", 32'(bus.b_req_ready_o), 32'd0);
      chk("rst_a_resp_valid", 32'(bus.a_resp_valid_o), 32'd0);
      chk("rst_en0", 32'(en0), 32'd0);
      chk("rst_en1", 32'(en1), 32'd0);
      cyc();

      // Single A read of 0x010
      rst = 1'b0; bus.b_req_valid_i = 1'b0; bus.a_resp_ready_i = 1'b1;
      @(negedge clk);
      chk("rd_en0", 32'(en0), 32'd1);
      chk("rd_a_ready", 32'(bus.a_req_ready_o), 32'd1);
      chk("rd_addr0", 32'(addr0), 32'h010);
      cyc();
      bus.a_req_valid_i = 1'b0;
      @(negedge clk);
      chk("rd_c1_valid", 32'(bus.a_resp_valid_o), 32'd0);
      cyc();
      @(negedge clk);
      chk("rd_c2_valid", 32'(bus.a_resp_valid_o), 32'd1);
      chk("rd_c2_data", bus.a_resp_rdata_o, 32'hA000_0010);
      cyc();
      @(negedge clk);
      chk("rd_c3_valid", 32'(bus.a_resp_valid_o), 32'd0);
      cyc();

      // Partial write then cross-stream readback
      bus.a_req_valid_i = 1'b1; bus.a_req_addr_i = 10'h020;
      bus.a_req_we_i = 4'b0011; bus.a_req_wdata_i = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("wr_en0", 32'(en0), 32'd1);
      chk("wr_we0", 32'(we0), 32'h3);
      cyc();
      bus.a_req_valid_i = 1'b0; bus.a_req_we_i = '0;
      @(negedge clk);
      chk("wr_we0_idle", 32'(we0), 32'h0);
      cyc();
      @(negedge clk);
      chk("wr_resp_valid", 32'(bus.a_resp_valid_o), 32'd1);
      chk("wr_resp_data", bus.a_resp_rdata_o, 32'h1122_BEEF);
      cyc();
      bus.b_req_valid_i = 1'b1; bus.b_req_addr_i = 10'h020; bus.b_resp_ready_i = 1'b1;
      @(negedge clk);
      chk("brd_en1", 32'(en1), 32'd1);
      cyc();
      bus.b_req_valid_i = 1'b0;
      cyc();
      @(negedge clk);
      chk("brd_valid", 32'(bus.b_resp_valid_o), 32'd1);
      chk("brd_data", bus.b_resp_rdata_o, 32'h1122_BEEF);
      cyc();

      // Four cycles of same-address collisions: grants A,B,A,B
      bus.a_req_valid_i = 1'b1; bus.a_req_addr_i = 10'h005;
      bus.b_req_valid_i = 1'b1; bus.b_req_addr_i = 10'h005;
      na = 0; nb = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 4) begin bus.a_req_valid_i = 1'b0; bus.b_req_valid_i = 1'b0; end
         @(negedge clk);
         if (k < 4) begin
            chk($sformatf("arb_en0_%0d", k), 32'(en0), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("arb_en1_%0d", k), 32'(en1), (k % 2 == 1) ? 32'd1 : 32'd0);
         end
         if (bus.a_resp_valid_o) begin
            na++;
            chk("arb_a_data", bus.a_resp_rdata_o, 32'hA000_0005);
         end
         if (bus.b_resp_valid_o) begin
            nb++;
            chk("arb_b_data", bus.b_resp_rdata_o, 32'hA000_0005);
         end
         cyc();
      end
      chk("arb_a_count", 32'(na), 32'd2);
      chk("arb_b_count", 32'(nb), 32'd2);

      // Backpressure: two accepted, then ready drops until a pop has happened
      bus.a_resp_ready_i = 1'b0;
      bus.a_req_valid_i = 1'b1; bus.a_req_addr_i = 10'h030;
      @(negedge clk);
      chk("bp_ready0", 32'(bus.a_req_ready_o), 32'd1);
      cyc();
      bus.a_req_addr_i = 10'h031;
      @(negedge clk);
      chk("bp_ready1", 32'(bus.a_req_ready_o), 32'd1);
      cyc();
      bus.a_req_addr_i = 10'h032;
      @(negedge clk);
      chk("bp_ready2", 32'(bus.a_req_ready_o), 32'd0);
      chk("bp_en0_blocked", 32'(en0), 32'd0);
      cyc();
      bus.a_req_valid_i = 1'b0;
      @(negedge clk);
      chk("bp_ready3", 32'(bus.a_req_ready_o), 32'd0);
      chk("bp_held_data", bus.a_resp_rdata_o, 32'hA000_0030);
      cyc();
      bus.a_resp_ready_i = 1'b1;
      @(negedge clk);
      chk("bp_pop1_valid", 32'(bus.a_resp_valid_o), 32'd1);
      chk("bp_pop1_data", bus.a_resp_rdata_o, 32'hA000_0030);
      chk("bp_pop1_ready", 32'(bus.a_req_ready_o), 32'd0);
      cyc();
      @(negedge clk);
      chk("bp_pop2_valid", 32'(bus.a_resp_valid_o), 32'd1);
      chk("bp_pop2_data", bus.a_resp_rdata_o, 32'hA000_0031);
      chk("bp_pop2_ready", 32'(bus.a_req_ready_o), 32'd1);
      cyc();
      @(negedge clk);
      chk("bp_empty", 32'(bus.a_resp_valid_o), 32'd0);
      cyc();

      // Different addresses are accepted together
      bus.a_req_valid_i = 1'b1; bus.a_req_addr_i = 10'h001;
      bus.b_req_valid_i = 1'b1; bus.b_req_addr_i = 10'h002;
      @(negedge clk);
      chk("par_a_ready", 32'(bus.a_req_ready_o), 32'd1);
      chk("par_b_ready", 32'(bus.b_req_ready_o), 32'd1);
      chk("par_en", {30'd0, en1, en0}, 32'd3);
      cyc();
      bus.a_req_valid_i = 1'b0; bus.b_req_valid_i = 1'b0;
      cyc();
      @(negedge clk);
      chk("par_a_data", bus.a_resp_valid_o ? bus.a_resp_rdata_o : 32'hX, 32'hA000_0001);
      chk("par_b_data", bus.b_resp_valid_o ? bus.b_resp_rdata_o : 32'hX, 32'hA000_0002);
      cyc();

      // One collision leaves the priority pointing at B
      bus.a_req_valid_i = 1'b1; bus.a_req_addr_i = 10'h007;
      bus.b_req_valid_i = 1'b1; bus.b_req_addr_i = 10'h007;
      @(negedge clk);
      chk("pre_a_ready", 32'(bus.a_req_ready_o), 32'd1);
      chk("pre_b_ready", 32'(bus.b_req_ready_o), 32'd0);
      cyc();
      bus.a_req_valid_i = 1'b0;
      @(negedge clk);
      chk("pre_b_en1", 32'(en1), 32'd1);
      cyc();
      bus.b_req_valid_i = 1'b0;
      cyc(); cyc(); cyc();

      // Reset with one response buffered and one read in flight
      bus.a_resp_ready_i = 1'b0;
      bus.a_req_valid_i = 1'b1; bus.a_req_addr_i = 10'h040;
      cyc();
      bus.a_req_addr_i = 10'h041;
      cyc();
      bus.a_req_valid_i = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", 32'(bus.a_resp_valid_o), 32'd0);
      chk("mid_rst_ready", 32'(bus.a_req_ready_o), 32'd0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_valid0", 32'(bus.a_resp_valid_o), 32'd0);
      cyc();
      @(negedge clk);
      chk("post_rst_valid1", 32'(bus.a_resp_valid_o), 32'd0);
      cyc();

      // Priority restored to A: a collision goes to A first
      bus.a_resp_ready_i = 1'b1; bus.b_resp_ready_i = 1'b1;
      bus.a_req_valid_i = 1'b1; bus.a_req_addr_i = 10'h042;
      bus.b_req_valid_i = 1'b1; bus.b_req_addr_i = 10'h042;
      @(negedge clk);
      chk("post_a_ready", 32'(bus.a_req_ready_o), 32'd1);
      chk("post_b_ready", 32'(bus.b_req_ready_o), 32'd0);
      chk("post_en0", 32'(en0), 32'd1);
      cyc();
      bus.a_req_valid_i = 1'b0;
      @(negedge clk);
      chk("post_b_en1", 32'(en1), 32'd1);
      cyc();
      bus.b_req_valid_i = 1'b0;
      @(negedge clk);
      chk("post_a_valid", 32'(bus.a_resp_valid_o), 32'd1);
      chk("post_a_data", bus.a_resp_rdata_o, 32'hA000_0042);
      cyc();
      @(negedge clk);
      chk("post_b_valid", 32'(bus.b_resp_valid_o), 32'd1);
      chk("post_b_data", bus.b_resp_rdata_o, 32'hA000_0042);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
